// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with 128-bit block refill.
// Define ICACHE_STATS_EN to add the HIT_COUNT/MISS_COUNT counters.
module icache_ctrl #(
  parameter int LINES   = 8,
  parameter int INDEX_W = 3
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         READ,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         IMEM_BUSYWAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
`ifdef ICACHE_STATS_EN
  input  logic         MEM_BUSYWAIT,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`else
  input  logic         MEM_BUSYWAIT
`endif
);

  localparam int TAG_W = 28 - INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_READ,
    S_UPDATE
  } state_e;

  state_e             state_q, state_d;
  logic [27:0]        miss_q, miss_d;
  logic [127:0]       blk_q, blk_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [127:0]       data_q [LINES];

  logic [INDEX_W-1:0] idx;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         off;
  logic               lookup_hit;
  logic               miss_start;
  logic               fill;
  logic               pc_unused;

  assign idx       = PC[INDEX_W+3:4];
  assign tag       = PC[31:INDEX_W+4];
  assign off       = PC[3:2];
  assign fill_idx  = miss_q[INDEX_W-1:0];
  assign pc_unused = ^PC[1:0];

  assign lookup_hit = (state_q == S_IDLE) && READ
                    && valid_q[idx]
                    && (tag_q[idx] == tag);
  assign miss_start = (state_q == S_IDLE) && READ
                    && !lookup_hit;

  assign MEM_ADDRESS = miss_q;

  always_comb begin
    state_d       = state_q;
    miss_d        = miss_q;
    blk_d         = blk_q;
    valid_d       = valid_q;
    fill          = 1'b0;
    INSTRUCTION   = 32'd0;
    IMEM_BUSYWAIT = 1'b0;
    MEM_READ      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (lookup_hit) begin
          INSTRUCTION = data_q[idx][{off, 5'b0} +: 32];
        end else if (miss_start) begin
          IMEM_BUSYWAIT = 1'b1;
          miss_d        = PC[31:4];
          state_d       = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        IMEM_BUSYWAIT = 1'b1;
        MEM_READ      = 1'b1;
        if (!MEM_BUSYWAIT) begin
          blk_d   = MEM_READDATA;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        IMEM_BUSYWAIT     = 1'b1;
        fill              = 1'b1;
        valid_d[fill_idx] = 1'b1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      miss_q  <= '0;
      blk_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      blk_q   <= blk_d;
      valid_q <= valid_d;
    end
  end

  // Tag/data need no reset: valid bits gate every read.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[fill_idx]  <= miss_q[27:INDEX_W];
      data_q[fill_idx] <= blk_q;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'd0, lookup_hit};
    miss_cnt_d = miss_cnt_q + {31'd0, miss_start};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed fetches against a
// transaction-level cache model plus hand-computed expectations.
module tb_icache_ctrl;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         READ;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         IMEM_BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA = '0;
  logic         MEM_BUSYWAIT = 1'b1;
`ifdef ICACHE_STATS_EN
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;
`endif

  icache_ctrl dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .READ          (READ),
    .PC            (PC),
    .INSTRUCTION   (INSTRUCTION),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_READDATA  (MEM_READDATA),
`ifdef ICACHE_STATS_EN
    .MEM_BUSYWAIT  (MEM_BUSYWAIT),
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
`else
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int mem_lat = 4;
  int preload_seq = 0;

  // Memory image: block b, word w holds ((b-1)<<4) + w + 1.
  function automatic logic [31:0] blk_word(
    input logic [27:0] b, input int w);
    logic [31:0] v;
    v = {4'd0, b};
    return ((v - 32'd1) << 4) + 32'(w) + 32'd1;
  endfunction

  function automatic logic [127:0] blk_data(input logic [27:0] b);
    logic [127:0] d;
    for (int w = 0; w < 4; w++) d[32*w +: 32] = blk_word(b, w);
    return d;
  endfunction

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: data valid after mem_lat cycles of MEM_READ.
  int rd_cycles = 0;
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && MEM_READ === 1'b1) begin
      rd_cycles++;
      MEM_BUSYWAIT = (rd_cycles < mem_lat);
      MEM_READDATA = blk_data(MEM_ADDRESS);
    end else begin
      rd_cycles    = 0;
      MEM_BUSYWAIT = 1'b1;
      MEM_READDATA = '0;
    end
  end

  // Cache model: lines hold a block address; a miss occupies
  // lat+2 cycles after detection before the next lookup.
  bit          m_valid [8];
  logic [27:0] m_blk [8];
  bit          m_busy;
  int          m_rel;
  int          m_lat;
  logic [27:0] m_miss;
  logic [31:0] m_hits;
  logic [31:0] m_misses;
  int          m_seq = 0;

  always @(negedge CLK) begin
    logic [31:0] e_ins;
    logic        e_bw;
    logic        e_mr;
    bit          do_hit;
    bit          do_miss;
    int          idx;
    if (RESET_N !== 1'b1) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 0;
      m_busy   = 0;
      m_hits   = '0;
      m_misses = '0;
      chk("rst_mem_read", MEM_READ, 1'b0);
      chk("rst_mem_address", MEM_ADDRESS, 28'd0);
      chk("rst_instruction", INSTRUCTION, 32'd0);
      if (!READ) chk("rst_busywait", IMEM_BUSYWAIT, 1'b0);
`ifdef ICACHE_STATS_EN
      chk("rst_hit_count", HIT_COUNT, 32'd0);
      chk("rst_miss_count", MISS_COUNT, 32'd0);
`endif
    end else begin
      e_ins   = '0;
      e_bw    = 1'b0;
      e_mr    = 1'b0;
      do_hit  = 0;
      do_miss = 0;
      idx     = int'(PC[6:4]);
      if (m_busy) begin
        m_rel++;
        e_bw = 1'b1;
        e_mr = (m_rel >= 1 && m_rel <= m_lat);
      end else if (READ) begin
        if (m_valid[idx] && m_blk[idx] == PC[31:4]) begin
          e_ins  = blk_word(PC[31:4], int'(PC[3:2]));
          do_hit = 1;
        end else begin
          e_bw    = 1'b1;
          do_miss = 1;
        end
      end
      chk("instruction", INSTRUCTION, e_ins);
      chk("imem_busywait", IMEM_BUSYWAIT, e_bw);
      chk("mem_read", MEM_READ, e_mr);
      if (e_mr) chk("mem_address", MEM_ADDRESS, m_miss);
`ifdef ICACHE_STATS_EN
      if (preload_seq != m_seq) begin
        m_seq  = preload_seq;
        m_hits = 32'hFFFF_FFFF;
      end
      chk("hit_count", HIT_COUNT, m_hits);
      chk("miss_count", MISS_COUNT, m_misses);
`endif
      if (do_hit) m_hits++;
      if (do_miss) begin
        m_misses++;
        m_busy = 1;
        m_rel  = 0;
        m_lat  = mem_lat;
        m_miss = PC[31:4];
      end else if (m_busy && m_rel == m_lat + 1) begin
        m_valid[int'(m_miss[2:0])] = 1;
        m_blk[int'(m_miss[2:0])]   = m_miss;
        m_busy = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic hit(input logic [31:0] pc,
                     input logic [31:0] exp);
    next_cycle();
    READ = 1'b1;
    PC   = pc;
    @(negedge CLK);
    chk("hit_instr", INSTRUCTION, exp);
    chk("hit_busywait", IMEM_BUSYWAIT, 1'b0);
    chk("hit_mem_read", MEM_READ, 1'b0);
  endtask

  // Cycles until busywait falls, counting MEM_READ cycles.
  task automatic wait_fill(output int n, output int mr,
                           output logic [27:0] a);
    n  = 0;
    mr = 0;
    a  = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!IMEM_BUSYWAIT) return;
      n++;
      if (MEM_READ) begin
        mr++;
        a = MEM_ADDRESS;
      end
    end
    checks++;
    errors++;
    $display("FAIL fill_timeout: busywait 1 after 100 cycles, want 0");
  endtask

  int          n;
  int          mr;
  logic [27:0] a;

  initial begin
    RESET_N = 1'b1;
    READ    = 1'b0;
    PC      = '0;
    #2 RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_mem_read", MEM_READ, 1'b0);
    chk("reset_busywait", IMEM_BUSYWAIT, 1'b0);
    chk("reset_instr", INSTRUCTION, 32'd0);
    next_cycle();
    RESET_N = 1'b1;

    // Cold miss, latency 4
    next_cycle();
    READ = 1'b1;
    PC   = 32'h10;
    #1 chk("cold_busy_now", IMEM_BUSYWAIT, 1'b1);
    wait_fill(n, mr, a);
    chk("cold_cycles", 32'(n), 32'd6);
    chk("cold_mr_cycles", 32'(mr), 32'd4);
    chk("cold_addr", a, 28'h1);
    chk("cold_instr", INSTRUCTION, 32'h1);

    hit(32'h14, 32'h2);
    hit(32'h18, 32'h3);
    hit(32'h1C, 32'h4);
`ifdef ICACHE_STATS_EN
    chk("stats_miss", MISS_COUNT, 32'd1);
    chk("stats_hit", HIT_COUNT, 32'd3);
`endif

    // Conflict on index 1, latency 1 then 2
    mem_lat = 1;
    next_cycle();
    PC = 32'h90;
    wait_fill(n, mr, a);
    chk("evict_cycles", 32'(n), 32'd3);
    chk("evict_mr_cycles", 32'(mr), 32'd1);
    chk("evict_addr", a, 28'h9);
    chk("evict_instr", INSTRUCTION, 32'h81);
    mem_lat = 2;
    next_cycle();
    PC = 32'h10;
    #1 chk("evicted_miss", IMEM_BUSYWAIT, 1'b1);
    wait_fill(n, mr, a);
    chk("refetch_addr", a, 28'h1);
    chk("refetch_instr", INSTRUCTION, 32'h1);

    // Branch during refill: both blocks fetched in turn
    mem_lat = 4;
    next_cycle();
    PC = 32'h20;
    @(negedge CLK);
    @(negedge CLK);
    next_cycle();
    PC = 32'h40;
    wait_fill(n, mr, a);
    chk("flush_cycles", 32'(n), 32'd10);
    chk("flush_mr_cycles", 32'(mr), 32'd7);
    chk("flush_addr", a, 28'h4);
    chk("flush_instr", INSTRUCTION, 32'h31);
    hit(32'h20, 32'h11);

    // Async reset in the middle of a refill
    next_cycle();
    PC = 32'h50;
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_rst_mem_read", MEM_READ, 1'b1);
    #2;
    RESET_N = 1'b0;
    READ    = 1'b0;
    #1;
    chk("async_mem_read", MEM_READ, 1'b0);
    chk("async_mem_addr", MEM_ADDRESS, 28'd0);
    chk("async_busywait", IMEM_BUSYWAIT, 1'b0);
    @(negedge CLK);
    next_cycle();
    RESET_N = 1'b1;
    READ    = 1'b1;
    PC      = 32'h10;
    #1 chk("post_rst_miss", IMEM_BUSYWAIT, 1'b1);
    wait_fill(n, mr, a);
    chk("post_rst_instr", INSTRUCTION, 32'h1);

`ifdef ICACHE_STATS_EN
    // Hit counter wraps from all-ones
    next_cycle();
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    preload_seq++;
    PC = 32'h14;
    #1 release dut.hit_cnt_q;
    next_cycle();
    READ = 1'b0;
    @(negedge CLK);
    chk("stats_wrap", HIT_COUNT, 32'd0);
`endif

    next_cycle();
    READ = 1'b0;
    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped, read-only instruction cache. It sits between the IF stage and the main instruction memory and is the responder to the fetch side of the IF/ID interface. It returns the 32-bit instruction for the fetch PC, and raises IMEM_BUSYWAIT while a miss is serviced. On a miss it refills a 128-bit block from instruction memory through a read/busywait handshake.

## Interface
Parameters:
- LINES, 8: number of cache lines (power of two).
- INDEX_W, 3: log2(LINES).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- READ  in  1  IF stage fetch request; high every cycle a PC is valid.
- PC  in  32  fetch byte address; PC[1:0] ignored.
- INSTRUCTION  out  32  fetched instruction.
- IMEM_BUSYWAIT  out  1  stall to IF stage and IF/ID register.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  28  block address, equal to PC[31:4] of the missing fetch.
- MEM_READDATA  in  128  refill block; word w at bits [32w+31:32w].
- MEM_BUSYWAIT  in  1  instruction memory busy; data valid in the cycle it is low while MEM_READ is high.
- HIT_COUNT, MISS_COUNT  out  32 each  present only with ICACHE_STATS_EN.

## Operation
- Address split:
  - word offset = PC[3:2]
  - index = PC[INDEX_W+3:4]
  - tag = PC[31:INDEX_W+4]
- Per line storage: valid bit, tag, 128-bit data.
- hit = READ & valid[index] & (tag_array[index] == tag). Evaluated combinationally in IDLE.
- INSTRUCTION = selected word when hit in IDLE. Otherwise 32'd0, so a stalled IF/ID register captures a bubble.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE: READ & !hit -> latch PC[31:4] into the miss register and go to MEM_READ. Otherwise stay in IDLE.
  - MEM_READ: MEM_READ=1, MEM_ADDRESS = miss register. On an edge with MEM_BUSYWAIT=0, capture MEM_READDATA and go to UPDATE. Otherwise stay in MEM_READ.
  - UPDATE: write data, tag and valid=1 into the line selected by the miss register, then go to IDLE.
- IMEM_BUSYWAIT = (IDLE & READ & !hit) | MEM_READ state | UPDATE state.
- READ=0 in IDLE: no lookup, IMEM_BUSYWAIT=0, INSTRUCTION=0.
- PC changing during a miss (branch flush): the refill still completes for the latched block. The lookup in IDLE then uses the current PC and may miss again. A refill is never aborted except by reset.
- No writes; the cache never writes back.

## Timing
- Reset (RESET_N low, asynchronous):
  - all valid bits 0, FSM to IDLE, miss register 0.
  - MEM_READ=0, MEM_ADDRESS=0, IMEM_BUSYWAIT=0 (with READ=0), INSTRUCTION=0.
  - counters 0.
- Reset mid-refill: MEM_READ drops immediately and the partial refill is discarded.
- Hit: zero-cycle latency; INSTRUCTION and IMEM_BUSYWAIT=0 are valid in the same cycle as PC.
- Miss (cycle 0 = detection in IDLE):
  - IMEM_BUSYWAIT=1 in cycle 0.
  - MEM_READ=1 from cycle 1 until the cycle in which MEM_BUSYWAIT is sampled low. Call that cycle k.
  - UPDATE in cycle k+1.
  - IDLE hit in cycle k+2 with IMEM_BUSYWAIT=0.
  - Penalty = memory latency + 2 cycles.
- MEM_READ deasserts on the edge leaving MEM_READ and is never high in UPDATE or IDLE.
- A refill that replaces a valid line with a different tag overwrites it; there is no victim handling.

## Configuration
- ICACHE_STATS_EN defined:
  - HIT_COUNT increments on each edge in IDLE with READ & hit.
  - MISS_COUNT increments on each IDLE -> MEM_READ transition.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on reset.
- Undefined: the counters and their ports are absent. All other behaviour is identical.

## Test plan
- Cold miss: after reset, READ=1, PC=0x00000010, memory latency 4 cycles returning block {0x4,0x3,0x2,0x1}:
  - IMEM_BUSYWAIT=1 at once.
  - MEM_ADDRESS=0x0000001, MEM_READ high 4 cycles.
  - INSTRUCTION=0x1 with busywait low 2 cycles after memory completes.
- Same-block hits: PC 0x14, 0x18, 0x1C -> INSTRUCTION 0x2, 0x3, 0x4 on consecutive cycles, busywait 0, MEM_READ never asserted.
- Conflict eviction (LINES=8): PC=0x00000090 (same index as 0x10, different tag):
  - miss, refill with MEM_ADDRESS=0x0000009.
  - PC=0x10 then misses again.
- PC change mid-refill: miss on 0x20, switch PC to 0x40 during MEM_READ:
  - refill for 0x20 completes.
  - a new miss on 0x40 follows.
  - line for 0x20 is valid afterwards.
- Async reset: RESET_N low while in MEM_READ:
  - MEM_READ=0 without waiting for a clock edge.
  - the previously valid 0x10 line now misses.
- ICACHE_STATS_EN: cold miss + 3 hits -> MISS_COUNT=1, HIT_COUNT=3. Preload 0xFFFFFFFF via force, one hit -> HIT_COUNT=0.
